// File: rtl/divider8bits_seq.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per clock,
// start/DONE handshake, divide-by-zero flagged and resolved without iterating.
module divider8bits_seq (
  input  logic       clk,
  input  logic       RESET,
  input  logic       start,
  input  logic [7:0] X,
  input  logic [7:0] Y,
  output logic [7:0] Q,
  output logic [7:0] R,
  output logic       BUSY,
  output logic       DONE,
  output logic       DIVZERO
);

  typedef enum logic [1:0] {IDLE, DIV, FIM} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [7:0]  divisor;
  logic [7:0]  rem;
  logic [7:0]  shift;

  logic [8:0]  p;
  logic [8:0]  diff;
  logic        ge;
  logic [7:0]  rem_nx;
  logic [7:0]  shift_nx;

  // 9-bit compare/subtract of {rem, next dividend bit} against the divisor
  always_comb begin
    p        = {rem, shift[7]};
    diff     = p - {1'b0, divisor};
    ge       = (p >= {1'b0, divisor});
    rem_nx   = ge ? diff[7:0] : p[7:0];
    shift_nx = {shift[6:0], ge};
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      divisor <= 8'd0;
      rem     <= 8'd0;
      shift   <= 8'd0;
      Q       <= 8'd0;
      R       <= 8'd0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      DIVZERO <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift   <= X;
            divisor <= Y;
            rem     <= 8'd0;
            cnt     <= 3'd0;
            BUSY    <= 1'b1;
            if (Y == 8'd0) begin
              // No iterations: result is fixed by convention, flag the fault
              state   <= FIM;
              DONE    <= 1'b1;
              Q       <= 8'hFF;
              R       <= X;
              DIVZERO <= 1'b1;
            end else begin
              state   <= DIV;
              Q       <= 8'd0;
              R       <= 8'd0;
              DIVZERO <= 1'b0;
            end
          end
        end
        DIV: begin
          rem   <= rem_nx;
          shift <= shift_nx;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            Q     <= shift_nx;
            R     <= rem_nx;
            state <= FIM;
            DONE  <= 1'b1;
          end
        end
        FIM: begin
          state <= IDLE;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider8bits_seq.sv
// Directed vector table plus handshake corner sequences and a random invariant
// sweep for divider8bits_seq.
module tb_divider8bits_seq;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       start = 1'b0;
  logic [7:0] X = 8'd0;
  logic [7:0] Y = 8'd0;
  logic [7:0] Q, R;
  logic       BUSY, DONE, DIVZERO;

  int tests = 0;
  int fails = 0;

  divider8bits_seq dut (
    .clk(clk), .RESET(RESET), .start(start), .X(X), .Y(Y),
    .Q(Q), .R(R), .BUSY(BUSY), .DONE(DONE), .DIVZERO(DIVZERO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One start pulse; lat = edges after the accepting edge until DONE is seen
  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic dz, output int lat,
                        output logic done_after, output logic busy_after);
    @(negedge clk);
    X = x; Y = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    X = 8'h5A; Y = 8'hA5;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      if (DONE) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    q = Q; r = R; dz = DIVZERO;
    @(posedge clk); #1;
    done_after = DONE;
    busy_after = BUSY;
  endtask

  vec_t       vt[11];
  logic [7:0] q, r;
  logic       dz, da, ba;
  int         lat;
  int         donecnt;
  int         done_at[3];
  int         nd;
  logic [7:0] bx[3];
  logic [7:0] by[3];
  logic [7:0] bq[3];
  logic [7:0] br[3];

  initial begin
    vt[0]  = '{8'd200, 8'd7,   8'd28,  8'd4,  1'b0};
    vt[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    vt[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
    vt[3]  = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0};
    vt[4]  = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
    vt[5]  = '{8'd13,  8'd0,   8'hFF,  8'd13, 1'b1};
    vt[6]  = '{8'd100, 8'd10,  8'd10,  8'd0,  1'b0};
    vt[7]  = '{8'd1,   8'd2,   8'd0,   8'd1,  1'b0};
    vt[8]  = '{8'd128, 8'd16,  8'd8,   8'd0,  1'b0};
    vt[9]  = '{8'd254, 8'd17,  8'd14,  8'd16, 1'b0};
    vt[10] = '{8'd9,   8'd4,   8'd2,   8'd1,  1'b0};

    // Reset state
    #2;
    chk("rst_Q", Q, 0);
    chk("rst_R", R, 0);
    chk("rst_BUSY", BUSY, 0);
    chk("rst_DONE", DONE, 0);
    chk("rst_DIVZERO", DIVZERO, 0);
    @(negedge clk);
    RESET = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vt[i].x, vt[i].y, q, r, dz, lat, da, ba);
      chk($sformatf("v%0d_Q", i), q, vt[i].q);
      chk($sformatf("v%0d_R", i), r, vt[i].r);
      chk($sformatf("v%0d_DIVZERO", i), dz, vt[i].dz);
      chk($sformatf("v%0d_latency", i), lat, vt[i].dz ? 0 : 8);
      chk($sformatf("v%0d_done_1cyc", i), da, 0);
      chk($sformatf("v%0d_busy_after", i), ba, 0);
      chk($sformatf("v%0d_Q_held", i), Q, vt[i].q);
    end

    // start re-pulsed while busy must be ignored
    @(negedge clk);
    X = 8'd200; Y = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    donecnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 3 || n == 7) begin
        start = 1'b1; X = 8'd50 + 8'(n); Y = 8'd3;
      end else begin
        start = 1'b0;
      end
      if (DONE) donecnt++;
    end
    start = 1'b0;
    chk("busy_repulse_done_count", donecnt, 1);
    chk("busy_repulse_Q", Q, 28);
    chk("busy_repulse_R", R, 4);

    // start held high: three back-to-back operations, DONE every 10 cycles
    bx = '{8'd200, 8'd99, 8'd77};
    by = '{8'd7,   8'd10, 8'd77};
    bq = '{8'd28,  8'd9,  8'd1};
    br = '{8'd4,   8'd9,  8'd0};
    nd = 0;
    @(negedge clk);
    X = bx[0]; Y = by[0]; start = 1'b1;
    for (int c = 0; c < 40 && nd < 3; c++) begin
      @(negedge clk);
      if (DONE) begin
        done_at[nd] = c;
        chk($sformatf("b2b%0d_Q", nd), Q, bq[nd]);
        chk($sformatf("b2b%0d_R", nd), R, br[nd]);
        nd++;
        if (nd < 3) begin
          X = bx[nd]; Y = by[nd];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_done_count", nd, 3);
    if (nd == 3) begin
      chk("b2b_spacing1", done_at[1] - done_at[0], 10);
      chk("b2b_spacing2", done_at[2] - done_at[1], 10);
    end
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    X = 8'd200; Y = 8'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("mid_BUSY_before_reset", BUSY, 1);
    RESET = 1'b1;
    #1;
    chk("arst_Q", Q, 0);
    chk("arst_R", R, 0);
    chk("arst_BUSY", BUSY, 0);
    chk("arst_DONE", DONE, 0);
    chk("arst_DIVZERO", DIVZERO, 0);
    @(negedge clk);
    RESET = 1'b0;
    donecnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (DONE) donecnt++;
    end
    chk("arst_no_done", donecnt, 0);
    run_op(8'd100, 8'd10, q, r, dz, lat, da, ba);
    chk("arst_after_Q", q, 10);
    chk("arst_after_R", r, 0);
    chk("arst_after_latency", lat, 8);

    // Random sweep of the division invariant
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] rx, ry;
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(1, 255));
      run_op(rx, ry, q, r, dz, lat, da, ba);
      tests++;
      if ((int'(q) * int'(ry) + int'(r)) != int'(rx) || r >= ry || dz
          || lat != 8 || da) begin
        fails++;
        $display("FAIL rand X=%0d Y=%0d: got Q=%0d R=%0d DZ=%0d lat=%0d done_after=%0d expected X=Q*Y+R, R<Y, lat=8",
                 rx, ry, q, r, dz, lat, da);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
